// File: rtl/cpu_reg_dump_if.sv
// Byte stream from the register dump engine to a debug sink.
// The master drives data/valid/last. The slave drives ready.
interface cpu_reg_dump_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;
   logic              last;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/cpu_reg_dump.sv
// Snapshots the CPU register bytes on i_Start and streams them out one byte per handshake (first byte 1 cycle later).
// Holds a byte until it is accepted, and freezes while i_Enable=0. Define CPU_REG_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module cpu_reg_dump #(
   parameter int NUM_BYTES = 12,
   parameter int DATA_W    = 8
) (
   input  logic                        i_Clk,
   input  logic                        i_Reset_n,
   input  logic                        i_Enable,
   input  logic                        i_Start,
   input  logic [NUM_BYTES*DATA_W-1:0] i_Regs,
   cpu_reg_dump_if.master              bus,
   output logic                        o_Busy,
   output logic                        o_Done
);

   localparam int                 IDX_W    = $clog2(NUM_BYTES);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_BYTES - 1);

`ifdef CPU_REG_DUMP_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, SEND, CHK} state_t;
`else
   typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

   state_t                      state;
   logic [IDX_W-1:0]            idx;
   logic [IDX_W-1:0]            idx_nxt;
   logic [NUM_BYTES*DATA_W-1:0] snap;
   logic [DATA_W-1:0]           data_q;
   logic                        valid_q;
   logic                        last_q;
   logic                        busy_q;
   logic                        done_q;

   assign idx_nxt = idx + IDX_W'(1);

`ifdef CPU_REG_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] chk_sum;

   always_comb begin
      chk_sum = '0;
      for (int n = 0; n < NUM_BYTES; n++) begin
         chk_sum = chk_sum ^ snap[n*DATA_W +: DATA_W];
      end
   end
`endif

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state   <= IDLE;
         idx     <= '0;
         snap    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (i_Enable) begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (i_Start) begin
                  snap    <= i_Regs;
                  idx     <= '0;
                  data_q  <= i_Regs[DATA_W-1:0];
                  valid_q <= 1'b1;
                  last_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= SEND;
               end
            end
            SEND: begin
               if (valid_q && bus.ready) begin
                  if (idx == LAST_IDX) begin
`ifdef CPU_REG_DUMP_CHECKSUM_EN
                     data_q  <= chk_sum;
                     last_q  <= 1'b1;
                     state   <= CHK;
`else
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state   <= IDLE;
`endif
                  end else begin
                     idx    <= idx_nxt;
                     data_q <= snap[int'(idx_nxt)*DATA_W +: DATA_W];
`ifdef CPU_REG_DUMP_CHECKSUM_EN
                     last_q <= 1'b0;
`else
                     last_q <= (idx_nxt == LAST_IDX);
`endif
                  end
               end
            end
`ifdef CPU_REG_DUMP_CHECKSUM_EN
            CHK: begin
               if (valid_q && bus.ready) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state   <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.data  = data_q;
   assign bus.valid = valid_q;
   assign bus.last  = last_q;
   assign o_Busy    = busy_q;
   assign o_Done    = done_q;

endmodule
